dense_sched: RTL and testbench
==============================

# dense_sched

Sequencer and arbiter that time-shares a single fixed-point MAC unit among the three dense layers of the denoiser: input dense (42→24, tanh), VAD output (24→1, sigmoid) and denoise output (96→22, sigmoid). It accepts layer-run requests, grants one layer at a time in round-robin order, and walks neurons and inputs. For each step it drives weight, bias and input addresses, MAC clear/enable strobes and the activation select for the shared tanh/sigmoid LUT stage. It holds no data itself; it sits between the GRU/feature control logic and the MAC, weight ROM and activation datapath.

## Interface
- FIXED, 32, datapath word width (informational; no data ports here)
- MAC_LAT, 2, MAC pipeline latency in cycles from last mac_en to accumulator final
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  3  run request per layer, level; bit0 input dense, bit1 VAD, bit2 denoise
- stall  in  1  input vector not ready; freezes MAC stepping
- grant  out  3  one-hot owner of the MAC, 0 when idle
- done  out  3  one-cycle pulse on the granted bit when its layer completes
- busy  out  1  high whenever grant≠0
- mac_clr  out  1  load accumulator with bias[b_addr]
- mac_en  out  1  accumulate weight[w_addr]*x[x_idx]
- w_addr  out  12  weight ROM address
- b_addr  out  6  bias ROM address
- x_idx  out  7  input vector index j
- out_valid  out  1  accumulator of neuron out_idx is final; apply scale and activation
- out_idx  out  5  neuron index i
- act_sel  out  1  0 = tanh, 1 = sigmoid

## Operation
- Fixed layer table. L0: N=42, M=24, weight base 0, bias base 0, tanh. L1: N=24, M=1, weight base 1008, bias base 24, sigmoid. L2: N=96, M=22, weight base 1032, bias base 25, sigmoid.
- Addressing: w_addr = Wbase + j*M + i; b_addr = Bbase + i; x_idx = j. Computed from registered counters, no multiplier; w_addr steps by M per input.
- FSM states:
  - IDLE: if any req is set, select a winner, set grant, go to BIAS.
  - BIAS: mac_clr=1 for 1 cycle, then go to MAC with j=0.
  - MAC: mac_en=1 while stall=0, j increments; after j=N-1 is issued, go to DRAIN.
  - DRAIN: MAC_LAT cycles.
  - OUT: out_valid=1 for 1 cycle. If i<M-1, increment i and go to BIAS; else go to DONE.
  - DONE: done pulse, grant cleared, return to IDLE.
- Arbitration: round-robin with pointer = last granted layer; search order starts at pointer+1 mod 3. Reset pointer is 2, so L0 wins first.
- A request is sampled only in IDLE. req held high through DONE is a new request and competes normally.
- stall in MAC: mac_en=0 and counters and addresses hold. stall is ignored in all other states.
- Reset mid-operation: all state discarded and every output driven to reset value immediately. No partial-layer resume.

## Timing
- Reset values: grant=0, done=0, busy=0, mac_clr=0, mac_en=0, w_addr=0, b_addr=0, x_idx=0, out_valid=0, out_idx=0, act_sel=0. FSM goes to IDLE, pointer to 2.
- All outputs are registered.
- grant/busy rise 1 cycle after req is seen in IDLE. mac_clr is high in that same cycle.
- Per neuron without stall: 1 (BIAS) + N (MAC) + MAC_LAT (DRAIN) + 1 (OUT) cycles.
- Layer time from grant rise to done pulse, MAC_LAT=2: L0 24*46 = 1104 cycles, L1 28, L2 2200. done is asserted on the cycle after the last OUT.
- Each stall cycle in MAC adds exactly 1 cycle.
- act_sel is valid for the whole grant; out_idx is valid while out_valid=1.
- Earliest next grant is 1 cycle after done (via IDLE).

## Test plan
- Reset, then req=3'b010 held until done: grant=010 for 28 cycles; 24 mac_en with w_addr 1008..1031, b_addr=24; one out_valid with out_idx=0, act_sel=1; done=010.
- req=3'b111 held: grants in order L0, L1, L2. Each done pulses its own bit. Spacing 1104/28/2200 cycles plus one IDLE cycle each.
- L0 run: first neuron w_addr sequence 0, 24, 48, …, 984; neuron 23 ends at 23+41*24 = 1007; 24 out_valid pulses with out_idx 0..23, act_sel=0.
- Stall 5 cycles at j=10 of L2 neuron 3: w_addr and x_idx hold at 1032+10*22+3 = 1255 and 10; mac_en=0 during the stall; layer time becomes 2205.
- rst_n low for 1 cycle mid-L2: all outputs are 0 asynchronously. req=3'b001 after release: L0 wins (pointer reset) and restarts from i=0, j=0.
- After L1 is granted, with req=3'b101 pending at DONE: L2 is granted next, then L0.

Source files
------------

// File: rtl/dense_sched.sv
// dense_sched: round-robin sequencer that time-shares one MAC unit across the three dense layers.
// Walks neurons i and inputs j of the granted layer, driving ROM addresses and MAC strobes.
module dense_sched #(
    parameter int unsigned MAC_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic        stall,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        busy,
    output logic        mac_clr,
    output logic        mac_en,
    output logic [11:0] w_addr,
    output logic [5:0]  b_addr,
    output logic [6:0]  x_idx,
    output logic        out_valid,
    output logic [4:0]  out_idx,
    output logic        act_sel
);

    typedef enum logic [2:0] {StIdle, StBias, StMac, StDrain, StOut, StDone} state_e;

    function automatic logic [6:0] lay_n(input logic [1:0] l);
        case (l)
            2'd0:    lay_n = 7'd42;
            2'd1:    lay_n = 7'd24;
            default: lay_n = 7'd96;
        endcase
    endfunction

    function automatic logic [4:0] lay_m(input logic [1:0] l);
        case (l)
            2'd0:    lay_m = 5'd24;
            2'd1:    lay_m = 5'd1;
            default: lay_m = 5'd22;
        endcase
    endfunction

    function automatic logic [11:0] lay_wb(input logic [1:0] l);
        case (l)
            2'd0:    lay_wb = 12'd0;
            2'd1:    lay_wb = 12'd1008;
            default: lay_wb = 12'd1032;
        endcase
    endfunction

    function automatic logic [5:0] lay_bb(input logic [1:0] l);
        case (l)
            2'd0:    lay_bb = 6'd0;
            2'd1:    lay_bb = 6'd24;
            default: lay_bb = 6'd25;
        endcase
    endfunction

    function automatic logic [1:0] nxt(input logic [1:0] p);
        nxt = (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  lay_q, lay_d, ptr_q, ptr_d;
    logic [4:0]  i_q, i_d, out_idx_q, out_idx_d;
    logic [6:0]  x_idx_q, x_idx_d;
    logic [11:0] w_row_q, w_row_d, w_addr_q, w_addr_d;
    logic [5:0]  b_addr_q, b_addr_d;
    logic [7:0]  drain_q, drain_d;
    logic [2:0]  grant_q, grant_d, done_q, done_d;
    logic        busy_q, busy_d, mac_clr_q, mac_clr_d, mac_en_q, mac_en_d;
    logic        out_valid_q, out_valid_d, act_sel_q, act_sel_d;

    logic [1:0]  cand1, cand2, win;
    logic [6:0]  n_cur;
    logic [4:0]  m_cur;

    // Search starts one past the last granted layer; the pointer itself is the last resort.
    always_comb begin
        cand1 = nxt(ptr_q);
        cand2 = nxt(cand1);
        if (req[cand1])      win = cand1;
        else if (req[cand2]) win = cand2;
        else                 win = ptr_q;
        n_cur = lay_n(lay_q);
        m_cur = lay_m(lay_q);
    end

    always_comb begin
        state_d     = state_q;
        lay_d       = lay_q;
        ptr_d       = ptr_q;
        i_d         = i_q;
        out_idx_d   = out_idx_q;
        x_idx_d     = x_idx_q;
        w_row_d     = w_row_q;
        w_addr_d    = w_addr_q;
        b_addr_d    = b_addr_q;
        drain_d     = drain_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        act_sel_d   = act_sel_q;
        done_d      = 3'b000;
        mac_clr_d   = 1'b0;
        mac_en_d    = 1'b0;
        out_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d   = StBias;
                    lay_d     = win;
                    ptr_d     = win;
                    grant_d   = 3'b001 << win;
                    busy_d    = 1'b1;
                    act_sel_d = (win != 2'd0);
                    mac_clr_d = 1'b1;
                    i_d       = 5'd0;
                    x_idx_d   = 7'd0;
                    w_row_d   = lay_wb(win);
                    w_addr_d  = lay_wb(win);
                    b_addr_d  = lay_bb(win);
                end
            end
            StBias: begin
                mac_en_d = 1'b1;
                state_d  = StMac;
            end
            StMac: begin
                // While stalled the pending input j is presented with mac_en low.
                if (mac_en_q) begin
                    if (x_idx_q == n_cur - 7'd1) begin
                        drain_d = 8'd0;
                        state_d = StDrain;
                    end else begin
                        x_idx_d  = x_idx_q + 7'd1;
                        w_addr_d = w_addr_q + 12'(m_cur);
                        mac_en_d = ~stall;
                    end
                end else begin
                    mac_en_d = ~stall;
                end
            end
            StDrain: begin
                if (drain_q == 8'(MAC_LAT - 1)) begin
                    state_d     = StOut;
                    out_valid_d = 1'b1;
                    out_idx_d   = i_q;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            StOut: begin
                if (i_q == m_cur - 5'd1) begin
                    state_d = StDone;
                    done_d  = grant_q;
                    grant_d = 3'b000;
                    busy_d  = 1'b0;
                end else begin
                    state_d   = StBias;
                    i_d       = i_q + 5'd1;
                    x_idx_d   = 7'd0;
                    w_row_d   = w_row_q + 12'd1;
                    w_addr_d  = w_row_q + 12'd1;
                    b_addr_d  = b_addr_q + 6'd1;
                    mac_clr_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lay_q       <= 2'd0;
            ptr_q       <= 2'd2;
            i_q         <= 5'd0;
            out_idx_q   <= 5'd0;
            x_idx_q     <= 7'd0;
            w_row_q     <= 12'd0;
            w_addr_q    <= 12'd0;
            b_addr_q    <= 6'd0;
            drain_q     <= 8'd0;
            grant_q     <= 3'b000;
            done_q      <= 3'b000;
            busy_q      <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            act_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lay_q       <= lay_d;
            ptr_q       <= ptr_d;
            i_q         <= i_d;
            out_idx_q   <= out_idx_d;
            x_idx_q     <= x_idx_d;
            w_row_q     <= w_row_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            drain_q     <= drain_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            mac_clr_q   <= mac_clr_d;
            mac_en_q    <= mac_en_d;
            out_valid_q <= out_valid_d;
            act_sel_q   <= act_sel_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign mac_clr   = mac_clr_q;
    assign mac_en    = mac_en_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = b_addr_q;
    assign x_idx     = x_idx_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign act_sel   = act_sel_q;

endmodule

// File: tb/tb_dense_sched.sv
// Self-checking bench for dense_sched: directed scenarios plus randomized requests and stalls,
// checked against a layer-table / round-robin reference model.
module tb_dense_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic        stall = 1'b0;
    logic [2:0]  grant, done;
    logic        busy, mac_clr, mac_en, out_valid, act_sel;
    logic [11:0] w_addr;
    logic [5:0]  b_addr;
    logic [6:0]  x_idx;
    logic [4:0]  out_idx;

    int tests = 0;
    int fails = 0;
    int ptr_m = 2;

    dense_sched #(.MAC_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .stall(stall), .grant(grant), .done(done),
        .busy(busy), .mac_clr(mac_clr), .mac_en(mac_en), .w_addr(w_addr), .b_addr(b_addr),
        .x_idx(x_idx), .out_valid(out_valid), .out_idx(out_idx), .act_sel(act_sel)
    );

    always #5 clk = ~clk;

    function automatic int lay_n(int l);
        return (l == 0) ? 42 : (l == 1) ? 24 : 96;
    endfunction
    function automatic int lay_m(int l);
        return (l == 0) ? 24 : (l == 1) ? 1 : 22;
    endfunction
    function automatic int lay_wb(int l);
        return (l == 0) ? 0 : (l == 1) ? 1008 : 1032;
    endfunction
    function automatic int lay_bb(int l);
        return (l == 0) ? 0 : (l == 1) ? 24 : 25;
    endfunction
    function automatic int pick(logic [2:0] r, int p);
        for (int k = 1; k <= 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {grant, done, busy, mac_clr, mac_en, w_addr, b_addr, x_idx, out_valid,
                  out_idx, act_sel}, 64'd0);
    endtask

    task automatic wait_grant(input int l, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (grant == 3'b000 && gap < 40);
        chk("grant_rise", {grant, mac_clr}, {3'(1 << l), 1'b1});
    endtask

    // Follows one layer from the grant-rise cycle; t = cycles from grant rise to done.
    task automatic run_layer(input int l, input int pct, input int sn, input int sj,
                             input int slen, input int abort_at, output int t);
        int n = lay_n(l), m = lay_m(l), wb = lay_wb(l), bb = lay_bb(l);
        int bi = 0, ii = 0, ij = 0, macs = 0, outs = 0, eff = 0, left = 0;
        bit active = 0, prev_eff = 0;
        t = -1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc == abort_at) begin
                stall = 1'b0;
                return;
            end
            if (done !== 3'b000) begin
                chk("done", {done, grant, busy}, {3'(1 << l), 3'b000, 1'b0});
                chk("mac_count", macs, n * m);
                chk("out_count", outs, m);
                chk("layer_time", cyc, (1 + n + 2 + 1) * m + eff);
                t = cyc;
                stall = 1'b0;
                ptr_m = l;
                return;
            end
            chk("grant_hold", {busy, act_sel, grant}, {1'b1, 1'(l != 0), 3'(1 << l)});
            if (prev_eff)
                chk("stall_hold", {mac_en, x_idx, w_addr}, {1'b0, 7'(ij), 12'(wb + ij * m + ii)});
            if (mac_clr) begin
                chk("b_addr", {b_addr, mac_en, out_valid}, {6'(bb + bi), 2'b00});
                bi++;
                active = 1;
            end
            if (mac_en) begin
                chk("w_addr_x_idx", {w_addr, x_idx}, {12'(wb + ij * m + ii), 7'(ij)});
                ij++;
                macs++;
            end
            if (out_valid) begin
                chk("out_idx", {out_idx, 7'(ij)}, {5'(ii), 7'(n)});
                ii++;
                ij = 0;
                outs++;
                active = 0;
            end
            if (left > 0) begin
                stall = 1'b1;
                left--;
            end else if (mac_en && ii == sn && ij == sj) begin
                stall = 1'b1;
                left = slen - 1;
            end else begin
                stall = ($urandom_range(99) < pct);
            end
            // A stall only costs a cycle once the MAC phase is running and inputs remain.
            prev_eff = stall && active && !mac_clr && ij < n;
            eff += int'(prev_eff);
            @(negedge clk);
        end
        chk("layer_timeout", done, 3'(1 << l));
        stall = 1'b0;
    endtask

    task automatic serve(input int pct, input int sn, input int sj, input int slen,
                         output int l, output int t, output int gap);
        l = pick(req, ptr_m);
        wait_grant(l, gap);
        run_layer(l, pct, sn, sj, slen, -1, t);
    endtask

    initial begin
        int l, t, g;
        #12;
        chk_zero("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;

        // VAD layer alone
        req = 3'b010;
        serve(0, -1, -1, 0, l, t, g);
        req = 3'b000;
        chk("l1_time", t, 28);

        // Fresh reset, all three requesting: L0, L1, L2 in order
        rst_n = 1'b0;
        ptr_m = 2;
        #1;
        chk_zero("reset2_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        req = 3'b111;
        serve(0, -1, -1, 0, l, t, g);
        chk("rr_first_l0", {l, t}, {32'd0, 32'd1104});
        serve(0, -1, -1, 0, l, t, g);
        chk("rr_second_l1", {l, t, g}, {32'd1, 32'd28, 32'd2});
        serve(0, -1, -1, 0, l, t, g);
        req = 3'b000;
        chk("rr_third_l2", {l, t, g}, {32'd2, 32'd2200, 32'd2});

        // Five-cycle stall at j=10 of L2 neuron 3
        req = 3'b100;
        serve(0, 3, 10, 5, l, t, g);
        req = 3'b000;
        chk("stall_l2_time", t, 2205);

        // Reset in the middle of L2, then L0 restarts from scratch
        req = 3'b100;
        l = pick(req, ptr_m);
        wait_grant(l, g);
        run_layer(l, 0, -1, -1, 0, 700, t);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset_mid_l2");
        @(negedge clk);
        chk_zero("reset_held");
        ptr_m = 2;
        req = 3'b001;
        rst_n = 1'b1;
        serve(0, -1, -1, 0, l, t, g);
        chk("after_reset_l0", {l, t}, {32'd0, 32'd1104});

        // L1 running with 3'b101 pending: L2 next, then L0
        req = 3'b010;
        l = pick(req, ptr_m);
        wait_grant(l, g);
        req = 3'b101;
        run_layer(l, 0, -1, -1, 0, -1, t);
        serve(0, -1, -1, 0, l, t, g);
        chk("pend_l2", {l, g}, {32'd2, 32'd2});
        serve(0, -1, -1, 0, l, t, g);
        chk("pend_l0", {l, g}, {32'd0, 32'd2});
        req = 3'b000;

        // Random requests and stalls
        for (int r = 0; r < 5; r++) begin
            req = 3'($urandom_range(7, 1));
            serve(($urandom_range(1) == 1) ? 25 : 0, -1, -1, 0, l, t, g);
        end
        req = 3'b000;
        repeat (3) @(negedge clk);
        chk("idle_no_grant", {grant, busy, mac_en, mac_clr}, 6'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
